// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the IF-stage ROM interface and ID, with a PC stall.
// Optional same-cycle bypass of an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [ADDR_W-1:0]        fetch_pc,
  input  logic [DATA_W-1:0]        fetch_inst,
  input  logic                     flush,
  output logic                     stall_pc,
  output logic                     id_valid,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [DATA_W-1:0]        id_inst,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              stall_q;
  logic              empty;
  logic              enq;
  logic              wr_en;
  logic              rd_en;

  assign empty = (count_q == '0);
  // A fetch arriving the cycle after a stall repeats the one already captured.
  assign enq   = fetch_valid && !stall_q && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass   = empty && enq;
  assign id_valid = !empty || bypass;
  assign id_pc    = !empty ? mem_pc[rd_ptr]   : (bypass ? fetch_pc   : '0);
  assign id_inst  = !empty ? mem_inst[rd_ptr] : (bypass ? fetch_inst : '0);
  assign wr_en    = enq && !(bypass && id_ready);
`else
  assign id_valid = !empty;
  assign id_pc    = empty ? '0 : mem_pc[rd_ptr];
  assign id_inst  = empty ? '0 : mem_inst[rd_ptr];
  assign wr_en    = enq;
`endif

  assign rd_en    = !empty && id_ready && !flush;
  // Stalling at DEPTH-1 leaves room for the fetch already in flight.
  assign stall_pc = !flush && (count_q >= CNT_W'(DEPTH - 1));
  assign count    = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      stall_q <= stall_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr]   <= fetch_pc;
      mem_inst[wr_ptr] <= fetch_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: scoreboard of accepted fetches compared at each ID handshake.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_inst = '0;
  logic        flush = 1'b0;
  logic        stall_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b0;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_inst(fetch_inst), .flush(flush), .stall_pc(stall_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_ready(id_ready), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every ID handshake must match the oldest accepted fetch.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (count > 3'(DEPTH)) begin
        errors++;
        $display("FAIL overflow: count=%0d limit=%0d", count, DEPTH);
      end
      if (id_valid && id_ready && !flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got pc=%h inst=%h expected none", id_pc, id_inst);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({id_pc, id_inst} !== e)
          begin
            errors++;
            $display("FAIL fifo_order: got pc=%h inst=%h expected pc=%h inst=%h",
                     id_pc, id_inst, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic push);
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_inst  = inst;
    id_ready    = rdy;
    if (push) exp_q.push_back({pc, inst});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_pc); end
    if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", id_pc); end
    if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", id_inst); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    logic [2:0] exp_c;
    exp_c = BYP ? 3'd0 : 3'd1;
    drive(1'b1, 32'h00, 32'hA0, 1'b1, 1'b1);
    checks += 2;
    if (count !== exp_c) begin errors++; $display("FAIL stream_count0: got %0d expected %0d", count, exp_c); end
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL stream_stall0: got %b expected 0", stall_pc); end
`ifndef FETCH_QUEUE_BYPASS_EN
    checks += 2;
    if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_latency_valid: got %b expected 1", id_valid); end
    if (id_pc !== 32'h00) begin errors++; $display("FAIL stream_latency_pc: got %h expected 0", id_pc); end
`endif
    drive(1'b1, 32'h04, 32'hA4, 1'b1, 1'b1);
    checks++;
    if (count !== exp_c) begin errors++; $display("FAIL stream_count1: got %0d expected %0d", count, exp_c); end
    drive(1'b1, 32'h08, 32'hA8, 1'b1, 1'b1);
    checks++;
    if (count !== exp_c) begin errors++; $display("FAIL stream_count2: got %0d expected %0d", count, exp_c); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks += 2;
    if (count !== 3'd0) begin errors++; $display("FAIL stream_drain: got %0d expected 0", count); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h00, 32'hA0, 1'b0, 1'b1);
    drive(1'b1, 32'h04, 32'hA4, 1'b0, 1'b1);
    drive(1'b1, 32'h08, 32'hA8, 1'b0, 1'b1);
    checks += 2;
    if (count !== 3'd3) begin errors++; $display("FAIL bp_count: got %0d expected 3", count); end
    if (stall_pc !== 1'b1) begin errors++; $display("FAIL bp_stall: got %b expected 1", stall_pc); end
    drive(1'b0, 32'h08, 32'hA8, 1'b0, 1'b0);
    // stall_q is now set, so the repeated pc 0x08 must be dropped
    drive(1'b1, 32'h08, 32'hA8, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL bp_drop: got %0d expected 3", count); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks += 2;
    if (count !== 3'd2) begin errors++; $display("FAIL bp_drain1: got %0d expected 2", count); end
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL bp_unstall: got %b expected 0", stall_pc); end
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks += 2;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", id_valid); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h40, 32'hB040, 1'b0, 1'b1);
    drive(1'b1, 32'h44, 32'hB044, 1'b0, 1'b1);
    drive(1'b1, 32'h48, 32'hB048, 1'b0, 1'b1);
    checks++;
    if (stall_pc !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b expected 1", stall_pc); end
    fetch_valid = 1'b1; fetch_pc = 32'h0C; fetch_inst = 32'hB00C; flush = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL flush_stall_forced: got %b expected 0", stall_pc); end
    @(posedge clk);
    #1;
    flush = 1'b0; fetch_valid = 1'b0;
    checks += 3;
    if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", id_valid); end
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall_pc); end
    drive(1'b1, 32'h100, 32'hB100, 1'b0, 1'b1);
    checks += 2;
    if (count !== 3'd1) begin errors++; $display("FAIL flush_target_count: got %0d expected 1", count); end
    if (id_pc !== 32'h100) begin errors++; $display("FAIL flush_target_pc: got %h expected 100", id_pc); end
    repeat (2) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL flush_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int m_count;
    int n_acc;
    logic m_sq, m_st, enq, deq, rdy;
    logic [31:0] pc;
    m_count = 0; n_acc = 0; m_sq = 1'b0; pc = 32'h200;
    for (int i = 0; i < 80 && n_acc < 12; i++) begin
      rdy  = (i < 3) ? 1'b0 : (i == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      m_st = (m_count >= DEPTH - 1);
      enq  = !m_sq;
      deq  = ((m_count != 0) || (BYP && enq)) && rdy;
      if (enq) n_acc++;
      drive(1'b1, pc, pc ^ 32'h5A5A_0000, rdy, enq);
      m_count = m_count + int'(enq) - int'(deq);
      m_sq = m_st;
      // A stalled PC repeats the same address on the next fetch.
      if (!m_st) pc = pc + 32'h4;
      checks += 2;
      if (count !== 3'(m_count)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, count, m_count); end
      if (stall_pc !== (m_count >= DEPTH - 1)) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected %b", i, stall_pc, (m_count >= DEPTH - 1)); end
      if (i == 3) begin
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL b2b_simul_at3: got %0d expected 3", count); end
      end
    end
    repeat (DEPTH + 1) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks += 3;
    if (n_acc < 12) begin errors++; $display("FAIL b2b_budget: got %0d accepted expected 12", n_acc); end
    if (count !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", count); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h300, 32'hC300, 1'b0, 1'b1);
    drive(1'b1, 32'h304, 32'hC304, 1'b0, 1'b1);
    fetch_valid = 1'b0;
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks += 3;
    if (count !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
    if (id_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", id_valid); end
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b expected 0", stall_pc); end
    #2;
    rst = 1'b1;
    drive(1'b1, 32'h308, 32'hC308, 1'b1, 1'b1);
    drive(1'b1, 32'h30C, 32'hC30C, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks += 2;
    if (count !== 3'd0) begin errors++; $display("FAIL arst_resume_count: got %0d expected 0", count); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL arst_missing: got %0d left expected 0", exp_q.size()); end
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    fetch_valid = 1'b1; fetch_pc = 32'h20; fetch_inst = 32'hD020; id_ready = 1'b1;
    exp_q.push_back({32'h20, 32'hD020});
    #1;
    checks += 2;
    if (id_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", id_valid); end
    if (id_pc !== 32'h20) begin errors++; $display("FAIL bypass_pc: got %h expected 20", id_pc); end
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    checks += 2;
    if (count !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", count); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL bypass_missing: got %0d left expected 0", exp_q.size()); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
